video_source_scheduler: RTL
===========================

Name: video_source_scheduler

Overview:
- Arbitrates the 24-bit pixel stream feeding the video output between two sources: the colour-bar pattern generator (SOURCE 0) and the frame-buffer pixel stream (SOURCE 1).
- Sequences both sources from the sink's per-pixel ready strobe and tracks the x/y raster position.
- Switches sources only at frame boundaries.
- Falls back to the pattern when the frame buffer underflows too often in a frame.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 600, active lines per frame.
- MAX_UNDERFLOW, 16, number of underflowed pixels in one FB frame that forces fallback to pattern.
- FILL_COLOR, 24'h000000, pixel emitted when the FB stream has no valid data.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- SinkReady  in  1  sink consumes the current Video pixel this cycle.
- ModeReq  in  1  1 = frame buffer requested; 0 = pattern requested; sampled only at frame boundary.
- PatternVideo  in  24  pixel from the pattern generator.
- PatternReady  out  1  advance strobe to the pattern generator's VideoReady input.
- PatternReset  out  1  one-cycle restart pulse to the pattern generator.
- FbValid  in  1  FB pixel is available.
- FbVideo  in  24  FB pixel.
- FbReady  out  1  FB pixel popped this cycle.
- Video  out  24  selected pixel.
- ActiveSource  out  1  0 = pattern, 1 = FB.
- FrameStart  out  1  registered pulse: first pixel of a new frame is now presented.
- Xpos  out  10  column of the current pixel.
- Ypos  out  10  line of the current pixel.
- UnderflowCount  out  8  saturating count of underflowed pixels in the current FB frame.

Behaviour:
- Reset values: state PAT, Xpos=0, Ypos=0, UnderflowCount=0, ActiveSource=0, FrameStart=0, PatternReset=1 for the reset cycle plus one cycle after release.
- Video output (combinational, zero latency):
  - PAT state: Video = PatternVideo.
  - FB state with FbValid=1: Video = FbVideo.
  - FB state with FbValid=0: Video = FILL_COLOR.
- Source handshakes:
  - PatternReady = SinkReady & (state==PAT).
  - FbReady = SinkReady & (state==FB) & FbValid. FbReady is never asserted in PAT, so the FB stream is never popped while not displayed.
- Raster counters:
  - Advance only on SinkReady.
  - Xpos wraps from H_ACTIVE-1 to 0; Ypos increments on X wrap and wraps from V_ACTIVE-1 to 0.
  - Boundary = SinkReady while Xpos==H_ACTIVE-1 and Ypos==V_ACTIVE-1.
- Underflow:
  - In FB, SinkReady & !FbValid counts as an underflow. The pixel still advances the raster and UnderflowCount increments, saturating at 255.
  - UnderflowCount clears at every boundary.
- State machine, evaluated only on the boundary cycle; the new state takes effect on the next cycle, which is pixel (0,0):
  - PAT -> FB when ModeReq=1 and FbValid=1. Otherwise stay in PAT; an FB request with no data waits a further frame.
  - FB -> PAT when ModeReq=0, or when UnderflowCount (including the boundary pixel) >= MAX_UNDERFLOW.
  - Any transition into PAT, and PAT->PAT at each boundary, asserts PatternReset for one cycle so the bars realign to the frame.
- FrameStart: one-cycle pulse on the cycle after each boundary, and on the first cycle after reset.
- Mid-frame behaviour:
  - ModeReq changes mid-frame have no effect until the boundary.
  - Reset mid-frame returns to PAT at (0,0) on the next cycle, discarding partial-frame counts.
- SinkReady=0 holds all counters, the state and Video stable.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, MAX_UNDERFLOW=2):
- Reset, then SinkReady=1 continuously, ModeReq=0 -> PatternReady=1 every cycle; Xpos sequence 0,1,2,3,0,1,2,3; FrameStart and PatternReset pulse every 8 accepted pixels; ActiveSource=0.
- ModeReq=1 raised at pixel (1,0), FbValid=1 -> switch occurs only after pixel (3,1); next cycle ActiveSource=1, Video=FbVideo, FbReady=1, PatternReady=0.
- FB mode, FbValid=0 for 3 accepted pixels in one frame -> Video=FILL_COLOR on those cycles; UnderflowCount reaches 3; at the boundary state returns to PAT with a PatternReset pulse; UnderflowCount=0 after.
- ModeReq=1 with FbValid=0 at the boundary -> stays in PAT for the next frame; enters FB at the following boundary once FbValid=1.
- SinkReady toggled 1,0,0,1 in FB -> FbReady asserted only on SinkReady cycles; Xpos advances by exactly 2; Video stable during stalls.
- Reset asserted at pixel (2,1) in FB -> next cycle ActiveSource=0, Xpos=Ypos=0, PatternReset=1, FbReady=0.

Source files
------------

// File: rtl/video_source_scheduler.sv
// video_source_scheduler
//
// Chooses which source feeds the 24-bit video output: the colour-bar pattern
// generator (source 0) or the frame-buffer pixel stream (source 1). Both
// sources are paced by the sink's per-pixel ready strobe. The scheduler also
// tracks the raster position. It changes source only at a frame boundary,
// which is the sink accepting the last pixel of the last line. It falls back
// to the pattern when the frame buffer underflows too often within one frame.
//
// Ports:
//   Clock, Reset    system clock; synchronous active-high reset
//   SinkReady       sink consumes the current Video pixel this cycle
//   ModeReq         1 = frame buffer wanted, 0 = pattern (sampled at boundary)
//   PatternVideo    pixel from the pattern generator
//   PatternReady    advance strobe to the pattern generator
//   PatternReset    one-cycle restart pulse to the pattern generator
//   FbValid/FbVideo frame-buffer pixel and its valid flag
//   FbReady         frame-buffer pixel popped this cycle
//   Video           selected pixel (combinational, zero latency)
//   ActiveSource    0 = pattern, 1 = frame buffer
//   FrameStart      first pixel of a new frame is being presented
//   Xpos/Ypos       raster position of the current pixel
//   UnderflowCount  saturating count of starved pixels in the current FB frame

module video_source_scheduler #(
  parameter int          H_ACTIVE      = 800,
  parameter int          V_ACTIVE      = 600,
  parameter int          MAX_UNDERFLOW = 16,
  parameter logic [23:0] FILL_COLOR    = 24'h000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        SinkReady,
  input  logic        ModeReq,
  input  logic [23:0] PatternVideo,
  output logic        PatternReady,
  output logic        PatternReset,
  input  logic        FbValid,
  input  logic [23:0] FbVideo,
  output logic        FbReady,
  output logic [23:0] Video,
  output logic        ActiveSource,
  output logic        FrameStart,
  output logic [9:0]  Xpos,
  output logic [9:0]  Ypos,
  output logic [7:0]  UnderflowCount
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [8:0] UF_LIMIT = 9'(MAX_UNDERFLOW);

  typedef enum logic {
    PAT = 1'b0,
    FB  = 1'b1
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       pat_rst_q;
  logic       frame_start_q;
  logic       boundary;
  logic       underflow;
  logic [7:0] uf_next;
  logic       fallback;

  // The boundary is the sink accepting the final pixel of the frame.
  assign boundary  = SinkReady && (Xpos == H_LAST) && (Ypos == V_LAST);
  assign underflow = SinkReady && (state == FB) && !FbValid;

  // This count includes the current pixel. The fallback decision made on the
  // boundary cycle must therefore see a starved boundary pixel as well.
  assign uf_next  = (underflow && (UnderflowCount != 8'hFF)) ? UnderflowCount + 8'd1
                                                             : UnderflowCount;
  assign fallback = {1'b0, uf_next} >= UF_LIMIT;

  always_comb begin
    // NOTE: assign a default before any branch. Without it, a path that
    // leaves next_state unassigned infers a latch.
    next_state = state;
    if (boundary) begin
      case (state)
        PAT: if (ModeReq && FbValid) next_state = FB;
        FB:  if (!ModeReq || fallback) next_state = PAT;
        default: next_state = PAT;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    // NOTE: use non-blocking assignments for every register here. Each
    // right-hand side then sees pre-edge values, whatever the statement order.
    if (Reset) begin
      state          <= PAT;
      Xpos           <= '0;
      Ypos           <= '0;
      UnderflowCount <= '0;
      pat_rst_q      <= 1'b1;
      frame_start_q  <= 1'b1;
    end else begin
      state         <= next_state;
      frame_start_q <= boundary;
      // Restart the bars at every frame that the pattern will be displaying.
      pat_rst_q     <= boundary && (next_state == PAT);

      if (SinkReady) begin
        if (Xpos == H_LAST) begin
          Xpos <= '0;
          Ypos <= (Ypos == V_LAST) ? '0 : Ypos + 10'd1;
        end else begin
          Xpos <= Xpos + 10'd1;
        end
      end

      UnderflowCount <= boundary ? 8'd0 : uf_next;
    end
  end

  // PatternReset also covers the cycle in which Reset is asserted. FrameStart
  // is held low during reset and pulses on the first cycle after release.
  assign PatternReset = Reset || pat_rst_q;
  assign FrameStart   = frame_start_q && !Reset;
  assign ActiveSource = (state == FB);

  assign PatternReady = SinkReady && (state == PAT);
  assign FbReady      = SinkReady && (state == FB) && FbValid;

  always_comb begin
    Video = PatternVideo;
    if (state == FB) Video = FbValid ? FbVideo : FILL_COLOR;
  end

endmodule
